// File: rtl/ripple_count_monitor.sv
// Sequence checker for a free-running WIDTH-bit counter: verifies +1 steps,
// tracks lock (IDLE/ACQUIRE/TRACK/LOST) and keeps saturating error/wrap stats.
module ripple_count_monitor #(
  parameter int WIDTH      = 4,
  parameter int CNT_W      = 8,
  parameter int MISS_LIMIT = 3,
  parameter int LOCK_RUN   = 4
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] COUNT_IN,
  input  logic             ENABLE,
  input  logic             CLEAR_STATS,
  output logic             SYNCED,
  output logic             ERROR_PULSE,
  output logic [CNT_W-1:0] ERR_COUNT,
  output logic [CNT_W-1:0] WRAP_COUNT,
  output logic [WIDTH-1:0] LAST_BAD,
  output logic [1:0]       STATE
);
  localparam int MW = $clog2(MISS_LIMIT + 1);
  localparam int GW = $clog2(LOCK_RUN + 1);

  typedef enum logic [1:0] {IDLE = 2'b00, ACQUIRE = 2'b01, TRACK = 2'b10, LOST = 2'b11} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] err;
    logic [CNT_W-1:0] wrap;
    logic [WIDTH-1:0] bad;
  } stats_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] prev_q, prev_n;
  logic [MW-1:0]    miss_q, miss_n;
  logic [GW-1:0]    good_q, good_n;
  logic             sync_q, sync_n;
  logic             pulse_q, pulse_n;
  stats_t           stats_q, stats_n;
  logic             err_inc, wrap_inc;

  logic [WIDTH-1:0] exp_v;
  logic             match, restart, at_max;

  assign exp_v   = prev_q + WIDTH'(1);
  assign match   = (COUNT_IN == exp_v);
  assign restart = (COUNT_IN == '0);
  assign at_max  = (prev_q == '1);

  always_comb begin
    state_n  = state_q;
    prev_n   = prev_q;
    miss_n   = miss_q;
    good_n   = good_q;
    sync_n   = sync_q;
    pulse_n  = 1'b0;
    err_inc  = 1'b0;
    wrap_inc = 1'b0;
    if (!ENABLE) begin
      state_n = IDLE;
      miss_n  = '0;
      good_n  = '0;
      sync_n  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_n = ACQUIRE;
        ACQUIRE: begin
          prev_n  = COUNT_IN;
          state_n = TRACK;
          sync_n  = 1'b1;
        end
        TRACK: begin
          if (match) begin
            prev_n   = COUNT_IN;
            miss_n   = '0;
            wrap_inc = at_max;
          end else if (restart) begin
            prev_n = '0;
            miss_n = '0;
          end else begin
            pulse_n = 1'b1;
            err_inc = 1'b1;
            miss_n  = miss_q + MW'(1);
            // Flywheel on the expected value so a lone glitch costs one error
            prev_n  = exp_v;
            if (miss_q == MW'(MISS_LIMIT - 1)) begin
              state_n = LOST;
              sync_n  = 1'b0;
              prev_n  = COUNT_IN;
              good_n  = '0;
            end
          end
        end
        LOST: begin
          prev_n = COUNT_IN;
          if (match) begin
            good_n = good_q + GW'(1);
            if (good_q == GW'(LOCK_RUN - 1)) begin
              state_n = TRACK;
              sync_n  = 1'b1;
              miss_n  = '0;
              good_n  = '0;
            end
          end else begin
            good_n = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    stats_n = stats_q;
    if (CLEAR_STATS) begin
      stats_n = '0;
    end else begin
      if (err_inc) begin
        stats_n.bad = COUNT_IN;
        if (stats_q.err != '1) stats_n.err = stats_q.err + CNT_W'(1);
      end
      if (wrap_inc && stats_q.wrap != '1) stats_n.wrap = stats_q.wrap + CNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      prev_q  <= '0;
      miss_q  <= '0;
      good_q  <= '0;
      sync_q  <= 1'b0;
      pulse_q <= 1'b0;
      stats_q <= '0;
    end else begin
      state_q <= state_n;
      prev_q  <= prev_n;
      miss_q  <= miss_n;
      good_q  <= good_n;
      sync_q  <= sync_n;
      pulse_q <= pulse_n;
      stats_q <= stats_n;
    end
  end

  assign SYNCED      = sync_q;
  assign ERROR_PULSE = pulse_q;
  assign ERR_COUNT   = stats_q.err;
  assign WRAP_COUNT  = stats_q.wrap;
  assign LAST_BAD    = stats_q.bad;
  assign STATE       = state_q;
endmodule

// File: tb/tb_ripple_count_monitor.sv
// Scoreboard bench for ripple_count_monitor: a behavioural model queues the
// expected outputs per edge, plus fixed expectations at scenario milestones.
module tb_ripple_count_monitor;
  logic       CLOCK, RESET, ENABLE, CLEAR_STATS;
  logic [3:0] COUNT_IN;
  logic       SYNCED, ERROR_PULSE;
  logic [7:0] ERR_COUNT, WRAP_COUNT;
  logic [3:0] LAST_BAD;
  logic [1:0] STATE;

  ripple_count_monitor #(.WIDTH(4), .CNT_W(8), .MISS_LIMIT(3), .LOCK_RUN(4)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .COUNT_IN(COUNT_IN), .ENABLE(ENABLE),
    .CLEAR_STATS(CLEAR_STATS), .SYNCED(SYNCED), .ERROR_PULSE(ERROR_PULSE),
    .ERR_COUNT(ERR_COUNT), .WRAP_COUNT(WRAP_COUNT), .LAST_BAD(LAST_BAD), .STATE(STATE));

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic [1:0] st;
    logic       sync;
    logic       pulse;
    logic [7:0] err;
    logic [7:0] wrap;
    logic [3:0] bad;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0, errors = 0, pulses = 0;

  // reference model state
  logic [1:0] m_st;
  logic [3:0] m_prev;
  int         m_miss, m_good, m_err, m_wrap;
  logic       m_sync, m_pulse;
  logic [3:0] m_bad;

  function automatic obs_t observed();
    obs_t o;
    o.st = STATE; o.sync = SYNCED; o.pulse = ERROR_PULSE;
    o.err = ERR_COUNT; o.wrap = WRAP_COUNT; o.bad = LAST_BAD;
    return o;
  endfunction

  task automatic model_reset();
    m_st = 2'b00; m_prev = 4'd0; m_miss = 0; m_good = 0;
    m_err = 0; m_wrap = 0; m_sync = 1'b0; m_pulse = 1'b0; m_bad = 4'd0;
  endtask

  task automatic model_step(input logic en, input logic clr, input logic [3:0] s);
    logic [3:0] e;
    logic       ei, wi;
    e = m_prev + 4'd1;
    ei = 1'b0; wi = 1'b0;
    m_pulse = 1'b0;
    if (!en) begin
      m_st = 2'b00; m_miss = 0; m_good = 0; m_sync = 1'b0;
    end else if (m_st == 2'b00) begin
      m_st = 2'b01;
    end else if (m_st == 2'b01) begin
      m_prev = s; m_st = 2'b10; m_sync = 1'b1;
    end else if (m_st == 2'b10) begin
      if (s == e) begin
        wi = (m_prev == 4'hf); m_prev = s; m_miss = 0;
      end else if (s == 4'd0) begin
        m_prev = 4'd0; m_miss = 0;
      end else begin
        m_pulse = 1'b1; ei = 1'b1; m_miss++;
        if (m_miss >= 3) begin
          m_st = 2'b11; m_sync = 1'b0; m_prev = s; m_good = 0;
        end else m_prev = e;
      end
    end else begin
      if (s == e) begin
        m_good++;
        if (m_good >= 4) begin m_st = 2'b10; m_sync = 1'b1; m_miss = 0; m_good = 0; end
      end else m_good = 0;
      m_prev = s;
    end
    if (clr) begin
      m_err = 0; m_wrap = 0; m_bad = 4'd0;
    end else begin
      if (ei) begin m_bad = s; if (m_err < 255) m_err++; end
      if (wi && m_wrap < 255) m_wrap++;
    end
  endtask

  // Drive one sample, queue the model's prediction, clock, then score it.
  task automatic cyc(input logic en, input logic clr, input logic [3:0] s);
    obs_t e, a;
    ENABLE = en; CLEAR_STATS = clr; COUNT_IN = s;
    model_step(en, clr, s);
    e.st = m_st; e.sync = m_sync; e.pulse = m_pulse;
    e.err = 8'(m_err); e.wrap = 8'(m_wrap); e.bad = m_bad;
    exp_q.push_back(e);
    @(posedge CLOCK); #1;
    a = observed();
    e = exp_q.pop_front();
    if (a.pulse) pulses++;
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL cycle t=%0t in=%0d: got st=%b sync=%b pulse=%b err=%0d wrap=%0d bad=%0d, want st=%b sync=%b pulse=%b err=%0d wrap=%0d bad=%0d",
               $time, s, a.st, a.sync, a.pulse, a.err, a.wrap, a.bad,
               e.st, e.sync, e.pulse, e.err, e.wrap, e.bad);
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; ENABLE = 1'b0; CLEAR_STATS = 1'b0; COUNT_IN = 4'd0;
    model_reset();
    #1;
    repeat (2) @(posedge CLOCK);
    #1;
    chk("reset_outputs", {STATE, SYNCED, ERROR_PULSE, ERR_COUNT, WRAP_COUNT, LAST_BAD}, 0);
    RESET = 1'b0;
  endtask

  task automatic test_clean_count();
    pulses = 0;
    cyc(1, 0, 4'd0);
    chk("clean_acquire_state", STATE, 1);
    chk("clean_acquire_sync", SYNCED, 0);
    cyc(1, 0, 4'd1);
    chk("clean_track_state", STATE, 2);
    chk("clean_track_sync", SYNCED, 1);
    for (int i = 2; i < 19; i++) cyc(1, 0, 4'(i));
    chk("clean_wrap", WRAP_COUNT, 1);
    chk("clean_err", ERR_COUNT, 0);
    chk("clean_no_pulse", pulses, 0);
  endtask

  task automatic test_glitch();
    cyc(1, 0, 4'd3); cyc(1, 0, 4'd4); cyc(1, 0, 4'd5); cyc(1, 0, 4'd6);
    cyc(1, 0, 4'd9);
    chk("glitch_pulse", ERROR_PULSE, 1);
    chk("glitch_err", ERR_COUNT, 1);
    chk("glitch_bad", LAST_BAD, 9);
    cyc(1, 0, 4'd8); cyc(1, 0, 4'd9);
    chk("glitch_err_after", ERR_COUNT, 1);
    chk("glitch_sync", SYNCED, 1);
  endtask

  task automatic test_restart();
    for (int i = 0; i <= 10; i++) cyc(1, 0, 4'(i));
    cyc(1, 0, 4'd0); cyc(1, 0, 4'd1);
    chk("restart_err", ERR_COUNT, 1);
    chk("restart_wrap", WRAP_COUNT, 1);
    chk("restart_sync", SYNCED, 1);
  endtask

  task automatic test_loss_relock();
    pulses = 0;
    cyc(1, 0, 4'd2); cyc(1, 0, 4'd3); cyc(1, 0, 4'd4);
    cyc(1, 0, 4'd12); cyc(1, 0, 4'd13); cyc(1, 0, 4'd14);
    chk("loss_pulses", pulses, 3);
    chk("loss_err", ERR_COUNT, 4);
    chk("loss_state", STATE, 3);
    chk("loss_sync", SYNCED, 0);
    cyc(1, 0, 4'd15); cyc(1, 0, 4'd0); cyc(1, 0, 4'd1);
    chk("relock_pending", STATE, 3);
    cyc(1, 0, 4'd2);
    chk("relock_state", STATE, 2);
    chk("relock_sync", SYNCED, 1);
    chk("relock_wrap", WRAP_COUNT, 1);
  endtask

  task automatic test_saturation_clear();
    logic [3:0] g;
    for (int i = 0; i < 300; i++) begin
      g = m_prev + 4'd9;
      if (g == 4'd0) g = m_prev + 4'd8;
      cyc(1, 0, g);
      cyc(1, 0, m_prev + 4'd1);
    end
    chk("sat_err", ERR_COUNT, 255);
    chk("sat_state", STATE, 2);
    g = m_prev + 4'd9;
    if (g == 4'd0) g = m_prev + 4'd8;
    cyc(1, 1, g);
    chk("clear_err", ERR_COUNT, 0);
    chk("clear_bad", LAST_BAD, 0);
  endtask

  task automatic test_enable_low();
    cyc(1, 0, m_prev + 4'd1);
    cyc(1, 0, 4'd7);
    cyc(0, 0, m_prev + 4'd1);
    chk("disable_state", STATE, 0);
    chk("disable_sync", SYNCED, 0);
    chk("disable_err_kept", ERR_COUNT, 1);
    cyc(1, 0, 4'd3); cyc(1, 0, 4'd4); cyc(1, 0, 4'd5);
    chk("reenable_state", STATE, 2);
  endtask

  task automatic test_async_reset();
    cyc(1, 0, 4'd6);
    cyc(1, 0, 4'd11);
    #3 RESET = 1'b1;
    model_reset();
    #1;
    chk("async_reset_outputs", {STATE, SYNCED, ERROR_PULSE, ERR_COUNT, WRAP_COUNT, LAST_BAD}, 0);
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    cyc(1, 0, 4'd1);
    cyc(1, 0, 4'd2);
    chk("async_retrack_state", STATE, 2);
    chk("async_retrack_sync", SYNCED, 1);
    cyc(1, 0, 4'd3);
  endtask

  initial begin
    test_reset();
    test_clean_count();
    test_glitch();
    test_restart();
    test_loss_relock();
    test_saturation_clear();
    test_enable_low();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
